// File: rtl/async_fifo_pkg.sv
// Shared helpers for the async FIFO pointer stages: Gray/binary conversion and
// sizing derived from the RAM address width.
package async_fifo_pkg;

    localparam int MAX_PW             = 32;
    localparam int DEFAULT_ADDR_WIDTH = 2;
    localparam int DEPTH              = 2 ** DEFAULT_ADDR_WIDTH;
    localparam int PW                 = DEFAULT_ADDR_WIDTH + 1;

    function automatic int depth_of(input int addr_width);
        return 2 ** addr_width;
    endfunction

    function automatic int pw_of(input int addr_width);
        return addr_width + 1;
    endfunction

    // Callers zero-extend narrower pointers, so the unused upper bits stay zero.
    function automatic logic [MAX_PW-1:0] bin2gray(input logic [MAX_PW-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // XOR prefix from the MSB downward.
    function automatic logic [MAX_PW-1:0] gray2bin(input logic [MAX_PW-1:0] gray);
        logic [MAX_PW-1:0] bin;
        bin[MAX_PW-1] = gray[MAX_PW-1];
        for (int i = MAX_PW - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/async_fifo_rptr_empty.sv
// Read-domain pointer stage of the async FIFO: read binary/Gray pointers,
// RAM read address, empty/almost-empty/level status and underflow pulse.
module async_fifo_rptr_empty
    import async_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH      = 2,
    parameter int ALMOST_EMPTY_TH = 1
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH:0]   rq_wptr_gray,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH:0]   rd_ptr_gray,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rd_level,
    output logic                  rd_underflow
);

    localparam int P_W = pw_of(ADDR_WIDTH);
    localparam logic [P_W-1:0] AE_TH = P_W'(ALMOST_EMPTY_TH);

    logic [P_W-1:0] rbin;
    logic [P_W-1:0] rbin_next;
    logic [P_W-1:0] rgray_next;
    logic [P_W-1:0] wbin;
    logic [P_W-1:0] level_next;
    logic           pop;

    // pop uses the registered empty so the synchronized write pointer never
    // reaches the pointer increment combinationally.
    always_comb begin
        pop        = rd_en & ~empty;
        rbin_next  = rbin + {{(P_W-1){1'b0}}, pop};
        rgray_next = P_W'(bin2gray(MAX_PW'(rbin_next)));
        wbin       = P_W'(gray2bin(MAX_PW'(rq_wptr_gray)));
        level_next = wbin - rbin_next;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            rbin         <= '0;
            rd_ptr_gray  <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_level     <= '0;
            rd_underflow <= 1'b0;
        end else begin
            rbin         <= rbin_next;
            rd_ptr_gray  <= rgray_next;
            empty        <= (rgray_next == rq_wptr_gray);
            almost_empty <= (level_next <= AE_TH);
            rd_level     <= level_next;
            rd_underflow <= rd_en & empty;
        end
    end

    assign rd_addr = rbin[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_async_fifo_rptr_empty.sv
// Self-checking bench for the read-domain pointer/empty stage, using directed
// scenarios plus randomized traffic against an occupancy-count model.
module tb_async_fifo_rptr_empty;

    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int TH    = 1;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          rd_en = 1'b0;
    logic [AW:0]   rq_wptr_gray = '0;
    logic [AW-1:0] rd_addr;
    logic [AW:0]   rd_ptr_gray;
    logic          empty;
    logic          almost_empty;
    logic [AW:0]   rd_level;
    logic          rd_underflow;

    int errors = 0;
    int checks = 0;

    // Model: absolute counts of writes seen and entries read.
    int wr_cnt = 0;
    int rd_cnt = 0;
    bit exp_empty = 1'b1;
    bit exp_uf = 1'b0;
    int exp_level = 0;

    async_fifo_rptr_empty #(.ADDR_WIDTH(AW), .ALMOST_EMPTY_TH(TH)) dut (
        .clk(clk), .nrst(nrst), .rd_en(rd_en), .rq_wptr_gray(rq_wptr_gray),
        .rd_addr(rd_addr), .rd_ptr_gray(rd_ptr_gray), .empty(empty),
        .almost_empty(almost_empty), .rd_level(rd_level), .rd_underflow(rd_underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [AW:0] gray_of(input int n);
        int b;
        b = n % (2 * DEPTH);
        return (AW+1)'(b ^ (b / 2));
    endfunction

    // Invariant monitors, sampled on the falling edge.
    logic        nrst_at_edge = 1'b0;
    logic [AW:0] prev_gray = '0;
    bit          prev_valid = 1'b0;
    always @(posedge clk) nrst_at_edge = nrst;
    always @(negedge clk) begin
        checks++;
        if (rd_level > DEPTH) begin
            errors++;
            $display("FAIL inv_level_bound: rd_level=%0d required <= %0d", rd_level, DEPTH);
        end
        checks++;
        if (empty !== (rd_level == 0)) begin
            errors++;
            $display("FAIL inv_empty_level: empty=%0b rd_level=%0d", empty, rd_level);
        end
        if (prev_valid && nrst_at_edge) begin
            checks++;
            if ($countones(prev_gray ^ rd_ptr_gray) > 1) begin
                errors++;
                $display("FAIL inv_gray_step: %b -> %b", prev_gray, rd_ptr_gray);
            end
        end
        prev_gray  = rd_ptr_gray;
        prev_valid = 1'b1;
    end

    task automatic cycle(input bit en, input bit wr);
        bit pop;
        rd_en = en;
        if (wr) wr_cnt++;
        rq_wptr_gray = gray_of(wr_cnt);
        pop = en && !exp_empty;
        exp_uf = en && exp_empty;
        @(posedge clk);
        if (pop) rd_cnt++;
        exp_level = wr_cnt - rd_cnt;
        exp_empty = (exp_level == 0);
        #1;
    endtask

    task automatic do_reset(input int n);
        nrst = 1'b0;
        rd_en = 1'b1;
        wr_cnt = 0;
        rd_cnt = 0;
        rq_wptr_gray = '0;
        repeat (n) @(posedge clk);
        #1;
        nrst = 1'b1;
        rd_en = 1'b0;
        exp_empty = 1'b1;
        exp_level = 0;
        exp_uf = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(2);
        checks++;
        if (rd_addr !== 0 || rd_ptr_gray !== 3'b000 || empty !== 1'b1 || almost_empty !== 1'b1
            || rd_level !== 0 || rd_underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset: addr=%0d gray=%b empty=%b ae=%b level=%0d uf=%b required 0 000 1 1 0 0",
                     rd_addr, rd_ptr_gray, empty, almost_empty, rd_level, rd_underflow);
        end
    endtask

    task automatic test_first_entry();
        cycle(1'b0, 1'b1);
        checks++;
        if (empty !== 1'b0 || rd_level !== 1 || almost_empty !== 1'b1) begin
            errors++;
            $display("FAIL first_write: empty=%b level=%0d ae=%b required 0 1 1", empty, rd_level, almost_empty);
        end
        cycle(1'b1, 1'b0);
        checks++;
        if (rd_addr !== 1 || rd_ptr_gray !== 3'b001 || empty !== 1'b1 || rd_level !== 0) begin
            errors++;
            $display("FAIL first_pop: addr=%0d gray=%b empty=%b level=%0d required 1 001 1 0",
                     rd_addr, rd_ptr_gray, empty, rd_level);
        end
    endtask

    task automatic test_full_drain();
        logic [AW:0] gseq [4] = '{3'b001, 3'b011, 3'b010, 3'b110};
        int          lseq [4] = '{3, 2, 1, 0};
        bit          aseq [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        do_reset(1);
        wr_cnt = 3;
        cycle(1'b0, 1'b1);
        checks++;
        if (rq_wptr_gray !== 3'b110 || rd_level !== DEPTH || almost_empty !== 1'b0 || empty !== 1'b0) begin
            errors++;
            $display("FAIL full_level: level=%0d ae=%b empty=%b required 4 0 0", rd_level, almost_empty, empty);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0);
            checks++;
            if (rd_ptr_gray !== gseq[i] || rd_level !== lseq[i] || almost_empty !== aseq[i]
                || empty !== (i == 3)) begin
                errors++;
                $display("FAIL drain_%0d: gray=%b level=%0d ae=%b empty=%b required %b %0d %b %b",
                         i, rd_ptr_gray, rd_level, almost_empty, empty, gseq[i], lseq[i], aseq[i], (i == 3));
            end
        end
    endtask

    task automatic test_wrap();
        logic [AW:0] gseq [8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        do_reset(1);
        checks++;
        if (rd_ptr_gray !== 3'b000) begin
            errors++;
            $display("FAIL wrap_start: gray=%b required 000", rd_ptr_gray);
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1);
            cycle(1'b1, 1'b0);
            checks++;
            if (rd_ptr_gray !== gseq[i] || rd_addr !== AW'((i + 1) % DEPTH) || empty !== 1'b1) begin
                errors++;
                $display("FAIL wrap_%0d: gray=%b addr=%0d empty=%b required %b %0d 1",
                         i, rd_ptr_gray, rd_addr, empty, gseq[i], (i + 1) % DEPTH);
            end
        end
    endtask

    task automatic test_underflow();
        logic [AW:0]   g0;
        logic [AW-1:0] a0;
        g0 = gray_of(rd_cnt);
        a0 = AW'(rd_cnt % DEPTH);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b0);
            checks++;
            if (rd_underflow !== 1'b1 || rd_ptr_gray !== g0 || rd_addr !== a0 || empty !== 1'b1) begin
                errors++;
                $display("FAIL underflow_%0d: uf=%b gray=%b addr=%0d empty=%b required 1 %b %0d 1",
                         i, rd_underflow, rd_ptr_gray, rd_addr, empty, g0, a0);
            end
        end
        cycle(1'b0, 1'b0);
        checks++;
        if (rd_underflow !== 1'b0) begin
            errors++;
            $display("FAIL underflow_clear: uf=%b required 0", rd_underflow);
        end
    endtask

    task automatic test_simultaneous_and_reset();
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        checks++;
        if (empty !== 1'b0 || rd_level !== 1) begin
            errors++;
            $display("FAIL simul_pop_write: empty=%b level=%0d required 0 1", empty, rd_level);
        end
        nrst = 1'b0;
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rd_addr !== 0 || rd_ptr_gray !== 0 || empty !== 1'b1 || almost_empty !== 1'b1
            || rd_level !== 0 || rd_underflow !== 1'b0) begin
            errors++;
            $display("FAIL midstream_reset: addr=%0d gray=%b empty=%b ae=%b level=%0d uf=%b required 0 000 1 1 0 0",
                     rd_addr, rd_ptr_gray, empty, almost_empty, rd_level, rd_underflow);
        end
    endtask

    task automatic test_random();
        bit en;
        bit wr;
        do_reset(1);
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 99) < 50);
            wr = ($urandom_range(0, 99) < 50) && (wr_cnt - rd_cnt < DEPTH);
            cycle(en, wr);
            checks++;
            if (rd_addr !== AW'(rd_cnt % DEPTH) || rd_ptr_gray !== gray_of(rd_cnt)
                || empty !== exp_empty || rd_level !== exp_level
                || almost_empty !== (exp_level <= TH) || rd_underflow !== exp_uf) begin
                errors++;
                $display("FAIL random_%0d: addr=%0d gray=%b empty=%b level=%0d ae=%b uf=%b required %0d %b %b %0d %b %b",
                         i, rd_addr, rd_ptr_gray, empty, rd_level, almost_empty, rd_underflow,
                         rd_cnt % DEPTH, gray_of(rd_cnt), exp_empty, exp_level, (exp_level <= TH), exp_uf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_entry();
        test_full_drain();
        test_wrap();
        test_underflow();
        test_simultaneous_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
